uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 174, sets clk cycles per serial bit; legal range 8..65535.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx_serial  input  1  asynchronous serial line from host, idle high.
REQ-005 data  output  8  received byte, valid while valid=1.
REQ-006 valid  output  1  byte available in holding register.
REQ-007 ready  input  1  consumer accepts byte in any cycle where valid&&ready.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 overrun  output  1  one-cycle pulse: byte completed while holding register still full.

Function
REQ-010 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1, no parity.
REQ-011 rx_serial SHALL pass a 2-flop synchronizer; all logic below uses the synchronized signal (rxs) and a delayed copy (rxs_d).
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE: a falling edge (rxs_d=1, rxs=0) at cycle t0 SHALL load the bit counter and enter START; a line held low without a falling edge SHALL NOT start a frame.
REQ-014 START: at t0+H, H=floor(CLKS_PER_BIT/2), sample rxs; 1 -> IDLE (glitch rejected, no outputs); 0 -> DATA, bit index 0.
REQ-015 DATA: data bit i (0..7) SHALL be sampled at t0+H+(i+1)*CLKS_PER_BIT and shifted in at bit 7 (shift right); after bit 7 -> STOP.
REQ-016 STOP: rxs SHALL be sampled at t0+H+9*CLKS_PER_BIT, then FSM -> IDLE the next cycle.
REQ-017 Stop sample 1 with holding register empty, or full but valid&&ready in the same cycle: load data, valid=1 from the next cycle.
REQ-018 Stop sample 1 with holding register full and ready=0: discard new byte, keep old data/valid, pulse overrun next cycle.
REQ-019 Stop sample 0: discard byte, pulse frame_err next cycle, holding register unchanged; a new frame needs a fresh falling edge (break does not retrigger).
REQ-020 valid SHALL fall the cycle after valid&&ready unless REQ-017 loads a new byte that same cycle; data SHALL be stable while valid=1.
REQ-021 Bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reload exactly at every sample point, with no cumulative drift.
REQ-022 frame_err and overrun SHALL never assert in the same cycle and never last longer than one cycle.

Reset
REQ-023 While reset=1: FSM=IDLE, synchronizer flops and rxs_d=1, counter=0, shift register=0, data=0x00, valid=0, frame_err=0, overrun=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, reception SHALL start only at the next falling edge.

Verification (CLKS_PER_BIT=8)
REQ-025 Send 0x55 with ready=1 -> valid high exactly one cycle, data=0x55, frame_err=0, overrun=0; valid rises t0+H+9*8+1.
REQ-026 Send 0xA3 then 0x0F back-to-back with ready=0 -> data=0xA3 held, valid=1, one overrun pulse at end of second frame; then ready=1 for one cycle -> valid=0.
REQ-027 Send 0xFF with stop bit forced 0, then line held low 40 cycles, then high -> one frame_err pulse, valid stays 0, no further frames.
REQ-028 Low glitch on rx_serial of 3 cycles from idle -> no state beyond START, no valid, no pulses.
REQ-029 Assert reset during data bit 4 of a frame, release, then send 0x3C -> no output from aborted frame; data=0x3C, valid=1.
REQ-030 Sweep all 256 byte values with random ready back-pressure and random inter-frame gaps of 0..20 cycles -> every byte accepted or flagged by overrun, never both; accepted bytes match the sent sequence in order.

Source files
------------

// File: rtl/uart_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module  : uart_rx_if
// Brief   : Byte-output bus of uart_rx: holding-register handshake plus error pulses.
// Revision: 1.0
// =============================================================================
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    modport master (
        output data,
        output valid,
        output frame_err,
        output overrun,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module  : uart_rx
// Brief   : 8N1 UART receiver with mid-bit sampling and a one-byte holding register.
// Revision: 1.0
// =============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 174
) (
    input  wire logic  clk,
    input  wire logic  reset,
    input  wire logic  rx_serial,
    uart_rx_if.master  bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_half_last = CNT_W'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t           state_q;
    logic             sync1_q;
    logic             rxs_q;
    logic             rxs_d_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             frame_err_q;
    logic             overrun_q;

    logic w_fall;
    logic w_sample;
    logic w_accept;

    assign w_fall   = rxs_d_q & ~rxs_q;
    assign w_sample = (cnt_q == '0);
    // The holding register can take a new byte if empty or drained this very cycle.
    assign w_accept = ~valid_q | bus.ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_d_q     <= 1'b1;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= rx_serial;
            rxs_q       <= sync1_q;
            rxs_d_q     <= rxs_q;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            if (valid_q && bus.ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_fall) begin
                        cnt_q   <= c_half_last;
                        state_q <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_sample) begin
                        if (rxs_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q     <= c_bit_last;
                            bit_idx_q <= 3'd0;
                            state_q   <= ST_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                ST_DATA: begin
                    if (w_sample) begin
                        shift_q <= {rxs_q, shift_q[7:1]};
                        cnt_q   <= c_bit_last;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                ST_STOP: begin
                    if (w_sample) begin
                        state_q <= ST_IDLE;
                        if (!rxs_q) begin
                            frame_err_q <= 1'b1;
                        end else if (w_accept) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule
`default_nettype wire
